// File: rtl/timebase_divider.sv
// Free-running timebase counter with gamma/seconds flag, per-bit rise pulses,
// alarm compare channel and CPU readback snapshot. All state advances on clk_en.
module timebase_divider #(
  parameter int unsigned WIDTH           = 15,
  parameter int unsigned KEEP_BITS       = 6,
  parameter logic [15:0] GAMMA_INIT_MASK = 16'h0010,
  parameter bit          ALARM_REPEAT    = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_en,
  input  logic [3:0]       cpu_id,
  input  logic             reset_gamma,
  input  logic             reset_divider,
  input  logic             reset_divider_keep,
  input  logic             alarm_load,
  input  logic [WIDTH-1:0] alarm_value,
  input  logic             alarm_clear,
  input  logic             snapshot,
  output logic [WIDTH-1:0] divider,
  output logic [WIDTH-1:0] divider_rise,
  output logic             gamma,
  output logic             tick_1s,
  output logic             alarm_armed,
  output logic             alarm_flag,
  output logic [WIDTH-1:0] divider_snapshot
);

  localparam logic [WIDTH-1:0] KEEP_MASK = (WIDTH'(1) << KEEP_BITS) - WIDTH'(1);

  logic [WIDTH-1:0] divider_q, divider_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] alarm_q, alarm_d;
  logic [WIDTH-1:0] snap_q, snap_d;
  logic             gamma_q, gamma_d;
  logic             tick_q, tick_d;
  logic             armed_q, armed_d;
  logic             flag_q, flag_d;

  logic [WIDTH-1:0] count_inc;
  logic             rollover;
  logic             match;

  // Next-state computation for one enabled edge.
  always_comb begin
    count_inc = divider_q + WIDTH'(1);
    divider_d = count_inc;
    rollover  = &divider_q;
    if (reset_divider) begin
      divider_d = '0;
      rollover  = 1'b0;
    end else if (reset_divider_keep) begin
      divider_d = count_inc & KEEP_MASK;
      rollover  = 1'b0;
    end

    rise_d = ~divider_q & divider_d;
    tick_d = rollover;

    gamma_d = gamma_q;
    if (rollover) begin
      gamma_d = 1'b1;
    end else if (reset_gamma) begin
      gamma_d = 1'b0;
    end

    // Compare uses the alarm register and armed state from before this edge.
    match = armed_q && (divider_d == alarm_q);

    flag_d = flag_q;
    if (match) begin
      flag_d = 1'b1;
    end else if (alarm_clear) begin
      flag_d = 1'b0;
    end

    alarm_d = alarm_q;
    armed_d = armed_q;
    if (alarm_load) begin
      alarm_d = alarm_value;
      armed_d = 1'b1;
    end else if (match && !ALARM_REPEAT) begin
      armed_d = 1'b0;
    end

    snap_d = snapshot ? divider_q : snap_q;
  end

  // State registers; reset overrides clk_en.
  always_ff @(posedge clk) begin
    if (reset) begin
      divider_q <= '0;
      rise_q    <= '0;
      alarm_q   <= '0;
      snap_q    <= '0;
      gamma_q   <= GAMMA_INIT_MASK[cpu_id];
      tick_q    <= 1'b0;
      armed_q   <= 1'b0;
      flag_q    <= 1'b0;
    end else if (clk_en) begin
      divider_q <= divider_d;
      rise_q    <= rise_d;
      alarm_q   <= alarm_d;
      snap_q    <= snap_d;
      gamma_q   <= gamma_d;
      tick_q    <= tick_d;
      armed_q   <= armed_d;
      flag_q    <= flag_d;
    end
  end

  assign divider          = divider_q;
  assign divider_rise     = rise_q;
  assign gamma            = gamma_q;
  assign tick_1s          = tick_q;
  assign alarm_armed      = armed_q;
  assign alarm_flag       = flag_q;
  assign divider_snapshot = snap_q;

endmodule

// File: tb/tb_timebase_divider.sv
// Bench for timebase_divider: directed plan plus random stimulus against an
// integer reference model; two instances cover both alarm repeat modes.
module tb_timebase_divider;

  localparam int unsigned W      = 15;
  localparam int          PERIOD = 32768;
  localparam int          KEEPM  = 64;
  localparam logic [15:0] GMASK  = 16'h0010;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         clk_en = 1'b0;
  logic [3:0]   cpu_id = 4'd4;
  logic         reset_gamma = 1'b0;
  logic         reset_divider = 1'b0;
  logic         reset_divider_keep = 1'b0;
  logic         alarm_load = 1'b0;
  logic [W-1:0] alarm_value = '0;
  logic         alarm_clear = 1'b0;
  logic         snapshot = 1'b0;

  logic [W-1:0] d_div [2];
  logic [W-1:0] d_rise [2];
  logic [W-1:0] d_snap [2];
  logic         d_gamma [2];
  logic         d_tick [2];
  logic         d_armed [2];
  logic         d_flag [2];

  int checks = 0;
  int failures = 0;

  // Reference model state (plain integers)
  int m_div, m_rise, m_snap, m_gamma, m_tick;
  int m_armed [2];
  int m_flag [2];
  int m_alarm [2];

  always #5 clk = ~clk;

  timebase_divider #(.ALARM_REPEAT(1'b0)) u_dut0 (
    .clk(clk), .reset(reset), .clk_en(clk_en), .cpu_id(cpu_id),
    .reset_gamma(reset_gamma), .reset_divider(reset_divider),
    .reset_divider_keep(reset_divider_keep), .alarm_load(alarm_load),
    .alarm_value(alarm_value), .alarm_clear(alarm_clear), .snapshot(snapshot),
    .divider(d_div[0]), .divider_rise(d_rise[0]), .gamma(d_gamma[0]),
    .tick_1s(d_tick[0]), .alarm_armed(d_armed[0]), .alarm_flag(d_flag[0]),
    .divider_snapshot(d_snap[0])
  );

  timebase_divider #(.ALARM_REPEAT(1'b1)) u_dut1 (
    .clk(clk), .reset(reset), .clk_en(clk_en), .cpu_id(cpu_id),
    .reset_gamma(reset_gamma), .reset_divider(reset_divider),
    .reset_divider_keep(reset_divider_keep), .alarm_load(alarm_load),
    .alarm_value(alarm_value), .alarm_clear(alarm_clear), .snapshot(snapshot),
    .divider(d_div[1]), .divider_rise(d_rise[1]), .gamma(d_gamma[1]),
    .tick_1s(d_tick[1]), .alarm_armed(d_armed[1]), .alarm_flag(d_flag[1]),
    .divider_snapshot(d_snap[1])
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model of one clk edge, from the spec rules.
  task automatic model_edge();
    int nxt;
    int roll;
    int hit;
    if (reset) begin
      m_div = 0; m_rise = 0; m_snap = 0; m_tick = 0;
      m_gamma = int'(GMASK[cpu_id]);
      for (int k = 0; k < 2; k++) begin
        m_armed[k] = 0; m_flag[k] = 0;
      end
    end else if (clk_en) begin
      roll = 0;
      if (reset_divider) nxt = 0;
      else if (reset_divider_keep) nxt = (m_div + 1) % KEEPM;
      else begin
        nxt  = (m_div + 1) % PERIOD;
        roll = (m_div == PERIOD - 1) ? 1 : 0;
      end
      m_rise = (~m_div) & nxt & (PERIOD - 1);
      m_tick = roll;
      if (roll != 0) m_gamma = 1;
      else if (reset_gamma) m_gamma = 0;
      for (int k = 0; k < 2; k++) begin
        hit = (m_armed[k] != 0 && nxt == m_alarm[k]) ? 1 : 0;
        if (hit != 0) m_flag[k] = 1;
        else if (alarm_clear) m_flag[k] = 0;
        if (alarm_load) begin
          m_alarm[k] = int'(alarm_value);
          m_armed[k] = 1;
        end else if (hit != 0 && k == 0) begin
          m_armed[k] = 0;
        end
      end
      if (snapshot) m_snap = m_div;
      m_div = nxt;
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("div%0d", k), int'(d_div[k]), m_div);
      check($sformatf("rise%0d", k), int'(d_rise[k]), m_rise);
      check($sformatf("snap%0d", k), int'(d_snap[k]), m_snap);
      check($sformatf("gamma%0d", k), int'(d_gamma[k]), m_gamma);
      check($sformatf("tick%0d", k), int'(d_tick[k]), m_tick);
      check($sformatf("armed%0d", k), int'(d_armed[k]), m_armed[k]);
      check($sformatf("flag%0d", k), int'(d_flag[k]), m_flag[k]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic run_to(input int target);
    int n = 0;
    while (m_div != target && n < 40000) begin
      step();
      n++;
    end
    check("run_to", int'(d_div[0]), target);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_alarm[k] = 0; m_armed[k] = 0; m_flag[k] = 0;
    end
    m_div = 0; m_rise = 0; m_snap = 0; m_gamma = 0; m_tick = 0;

    // Reset, cpu_id 4 then 0
    step(); step();
    check("rst_gamma_cpu4", int'(d_gamma[0]), 1);
    check("rst_div", int'(d_div[0]), 0);
    check("rst_snap", int'(d_snap[0]), 0);
    cpu_id = 4'd0;
    step();
    check("rst_gamma_cpu0", int'(d_gamma[0]), 0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check("en_low_div", int'(d_div[0]), 0);

    // Full rollover with reset_gamma at the wrap edge
    clk_en = 1'b1;
    for (int i = 0; i < PERIOD - 1; i++) step();
    check("pre_wrap", int'(d_div[0]), 32'h7FFF);
    reset_gamma = 1'b1;
    step();
    reset_gamma = 1'b0;
    check("wrap_div", int'(d_div[0]), 0);
    check("wrap_gamma", int'(d_gamma[0]), 1);
    check("wrap_tick", int'(d_tick[0]), 1);
    check("wrap_rise", int'(d_rise[0]), 0);
    clk_en = 1'b0;
    step(); step(); step();
    check("tick_hold", int'(d_tick[0]), 1);
    clk_en = 1'b1;
    step();
    check("post_div", int'(d_div[0]), 1);
    check("post_tick", int'(d_tick[0]), 0);
    check("post_rise", int'(d_rise[0]), 1);

    // reset_divider_keep behaviour
    run_to(32'h1234);
    reset_divider_keep = 1'b1;
    step();
    reset_divider_keep = 1'b0;
    check("keep_div", int'(d_div[0]), 32'h35);
    check("keep_rise", int'(d_rise[0]), 32'h1);
    run_to(32'h123F);
    reset_divider_keep = 1'b1;
    reset_divider = 1'b1;
    step();
    reset_divider_keep = 1'b0;
    reset_divider = 1'b0;
    check("both_div", int'(d_div[0]), 0);
    check("both_rise", int'(d_rise[0]), 0);
    run_to(32'h123F);
    reset_divider_keep = 1'b1;
    step();
    reset_divider_keep = 1'b0;
    check("keep_wrap_div", int'(d_div[0]), 0);
    check("keep_wrap_tick", int'(d_tick[0]), 0);

    // Alarm and snapshot
    run_to(5);
    alarm_load = 1'b1;
    alarm_value = 15'h0010;
    reset_gamma = 1'b1;
    step();
    alarm_load = 1'b0;
    reset_gamma = 1'b0;
    check("alarm_armed", int'(d_armed[0]), 1);
    check("gamma_cleared", int'(d_gamma[0]), 0);
    run_to(32'hF);
    alarm_clear = 1'b1;
    step();
    check("match_flag0", int'(d_flag[0]), 1);
    check("match_armed0", int'(d_armed[0]), 0);
    check("match_armed1", int'(d_armed[1]), 1);
    step();
    alarm_clear = 1'b0;
    check("clear_flag0", int'(d_flag[0]), 0);
    check("clear_flag1", int'(d_flag[1]), 0);
    run_to(32'h7FFF);
    snapshot = 1'b1;
    step();
    snapshot = 1'b0;
    check("snap_val", int'(d_snap[0]), 32'h7FFF);
    check("snap_div", int'(d_div[0]), 0);
    check("snap_gamma", int'(d_gamma[0]), 1);
    run_to(32'h10);
    check("repeat_flag1", int'(d_flag[1]), 1);
    check("repeat_flag0", int'(d_flag[0]), 0);

    // Random stimulus
    for (int i = 0; i < 3000; i++) begin
      clk_en             = ($urandom_range(0, 3) != 0);
      reset_divider      = ($urandom_range(0, 63) == 0);
      reset_divider_keep = ($urandom_range(0, 47) == 0);
      reset_gamma        = ($urandom_range(0, 15) == 0);
      alarm_load         = ($urandom_range(0, 31) == 0);
      alarm_clear        = ($urandom_range(0, 15) == 0);
      snapshot           = ($urandom_range(0, 7) == 0);
      alarm_value        = W'((m_div + int'($urandom_range(0, 40))) % (($urandom_range(0, 1) != 0) ? KEEPM : PERIOD));
      step();
    end
    clk_en = 1'b1;
    reset_divider = 1'b0; reset_divider_keep = 1'b0; reset_gamma = 1'b0;
    alarm_load = 1'b0; alarm_clear = 1'b0; snapshot = 1'b0;

    // Mid-count reset with alarm armed and flag set, clk_en low
    reset_divider = 1'b1;
    step();
    reset_divider = 1'b0;
    alarm_load = 1'b1;
    alarm_value = 15'h0004;
    reset_gamma = 1'b1;
    step();
    alarm_load = 1'b0;
    reset_gamma = 1'b0;
    run_to(4);
    snapshot = 1'b1;
    alarm_load = 1'b1;
    alarm_value = 15'h0100;
    step();
    snapshot = 1'b0;
    alarm_load = 1'b0;
    check("pre_rst_flag", int'(d_flag[0]), 1);
    check("pre_rst_armed", int'(d_armed[0]), 1);
    check("pre_rst_snap", int'(d_snap[0]), 4);
    clk_en = 1'b0;
    cpu_id = 4'd4;
    reset = 1'b1;
    step();
    check("mid_rst_div", int'(d_div[0]), 0);
    check("mid_rst_flag", int'(d_flag[0]), 0);
    check("mid_rst_armed", int'(d_armed[0]), 0);
    check("mid_rst_snap", int'(d_snap[0]), 0);
    check("mid_rst_gamma", int'(d_gamma[0]), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/timebase_divider.md
Name: timebase_divider

Overview:
Parametrised free-running timebase for the SM5xx CPU family, replacing the fixed 15-bit divider. It counts enabled clocks (32.768 kHz ticks) and provides:
- the gamma (seconds) flag and a rollover wake tick;
- per-bit rising-edge pulses for any consumer needing 1 kHz, 64 Hz or 4 Hz events;
- a one-shot/repeating alarm compare channel;
- a snapshot register for coherent CPU readback.

Parameters:
WIDTH, 15, counter width; rollover period is 2^WIDTH enabled clocks.
KEEP_BITS, 6, number of low bits preserved (incremented) by reset_divider_keep; 1..WIDTH-1.
GAMMA_INIT_MASK, 16'h0010, bit n set means gamma resets to 1 when cpu_id==n.
ALARM_REPEAT, 0, 0 = alarm disarms on match; 1 = stays armed.

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
clk_en  in  1  CPU-rate enable; all state changes and input sampling occur only on enabled edges (except reset)
cpu_id  in  4  CPU variant, sampled during reset only
reset_gamma  in  1  clear gamma
reset_divider  in  1  clear whole counter
reset_divider_keep  in  1  clear upper bits, keep incremented low KEEP_BITS
alarm_load  in  1  load alarm_value and arm
alarm_value  in  WIDTH  alarm compare value
alarm_clear  in  1  clear alarm_flag
snapshot  in  1  latch counter into divider_snapshot
divider  out  WIDTH  current count
divider_rise  out  WIDTH  per-bit 0->1 pulse
gamma  out  1  seconds flag
tick_1s  out  1  rollover pulse
alarm_armed  out  1  alarm pending
alarm_flag  out  1  alarm matched, sticky
divider_snapshot  out  WIDTH  latched count

Behaviour:
- Reset values: divider=0, divider_rise=0, tick_1s=0, alarm_armed=0, alarm_flag=0, divider_snapshot=0, gamma=GAMMA_INIT_MASK[cpu_id]. Reset overrides clk_en and all other inputs.
- Enabled edges: next-count priority is reset_divider > reset_divider_keep > increment.
  - reset_divider: next=0.
  - reset_divider_keep: next[KEEP_BITS-1:0]=(divider+1)[KEEP_BITS-1:0]; upper bits 0.
  - Increment: next=divider+1, modulo 2^WIDTH.
- Rollover: only a plain increment from all-ones sets gamma=1 and tick_1s=1 at the same edge that divider becomes 0. Either reset mode suppresses rollover.
- Gamma priority: rollover set wins over reset_gamma in the same cycle. Otherwise reset_gamma clears gamma; otherwise gamma holds.
- Pulse outputs: tick_1s and divider_rise are registered and recomputed every enabled edge.
  - divider_rise[i] = ~divider[i] & next[i].
  - Both pulses hold until the next enabled edge, so each lasts one clk_en period, not one clk cycle.
  - Both are cleared on an enabled edge with no new event.
  - No bit can rise via reset_divider. Low bits can rise via reset_divider_keep.
- Alarm:
  - alarm_load: the alarm register takes alarm_value and alarm_armed=1.
  - A match (armed & next==alarm register) sets alarm_flag at the same edge divider takes that value.
  - Match is evaluated against the old alarm register and old armed state. A load in the same cycle takes effect next edge.
  - On a match with ALARM_REPEAT=0, armed clears unless alarm_load is asserted in the same cycle (load wins).
  - alarm_flag: a match set wins over alarm_clear; otherwise alarm_clear clears it.
  - Matches caused by reset_divider or reset_divider_keep count.
- Snapshot: divider_snapshot takes the pre-update divider value. It holds otherwise.
- clk_en low: all registers hold, including pulse outputs. Inputs are ignored.

Test Plan:
- Reset with cpu_id=4, then cpu_id=0 -> gamma=1, then gamma=0; all other outputs 0; clk_en held low for 10 clocks -> divider stays 0.
- Run 32767 enabled clocks, assert reset_gamma on the 32768th -> divider=0, gamma=1, tick_1s=1 for exactly one clk_en period, divider_rise=0; next enabled edge divider=1, tick_1s=0, divider_rise[0]=1.
- Divider=0x123F, reset_divider_keep and reset_divider together -> divider=0, no rise. Repeat with keep alone -> divider=0x0000 (low 6 of 0x1240), and repeat from 0x1234 -> divider=0x0035, divider_rise=0x0001.
- Alarm: alarm_load with alarm_value=0x0010 at divider=0x0005 -> alarm_armed=1; alarm_flag=1 when divider=0x0010, armed=0 (ALARM_REPEAT=0); alarm_clear at the match edge is ignored, a later alarm_clear clears the flag. With ALARM_REPEAT=1 the flag re-sets 32768 enabled clocks later.
- Snapshot asserted at divider=0x7FFF -> divider_snapshot=0x7FFF while divider=0x0000 and gamma=1.
- Reset asserted mid-count with alarm armed and flag set -> all state returns to reset values next clk edge, independent of clk_en.
